// File: rtl/multi_channel_pulse_generator_pkg.sv
// Shared types for the multi-channel pulse generator: channel modes, FSM
// states and the cfg_ch width helper.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    MODE_DISABLED   = 2'd0,
    MODE_CONTINUOUS = 2'd1,
    MODE_ONE_SHOT   = 2'd2,
    MODE_BURST      = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // A single channel still needs a 1-bit select field.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_channel_pulse_generator_if.sv
// Configuration write bus: one shadow-config write per cycle to channel cfg_ch.
interface multi_channel_pulse_generator_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
);
  localparam int CH_W = pulse_gen_pkg::ch_w(NUM_CH);

  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_width;
  logic [1:0]         cfg_mode;
  logic [BURST_W-1:0] cfg_burst;

  modport master (output cfg_we, cfg_ch, cfg_period, cfg_width, cfg_mode, cfg_burst);
  modport slave  (input  cfg_we, cfg_ch, cfg_period, cfg_width, cfg_mode, cfg_burst);
endinterface

// File: rtl/multi_channel_pulse_generator_channel.sv
// One pulse channel: shadow/active config, IDLE/RUN FSM, period and burst counters.
module pulse_channel
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [CNT_W-1:0]   wr_period,
  input  logic [CNT_W-1:0]   wr_width,
  input  mode_e              wr_mode,
  input  logic [BURST_W-1:0] wr_burst,
  input  logic               start,
  input  logic               stop,
  output logic               pulse_out,
  output logic               busy,
  output logic               done
);

  typedef struct packed {
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   width;
    mode_e              mode;
    logic [BURST_W-1:0] burst;
  } cfg_t;

  ch_state_e          state, state_n;
  logic [CNT_W-1:0]   k, k_n;
  logic [BURST_W-1:0] bcnt, bcnt_n;
  cfg_t               act, act_n, shd;
  logic               done_n, pulse_n;
  logic               last;
  logic [BURST_W:0]   n_eff;
  logic               burst_last;

  assign last       = (k == act.period - CNT_W'(1));
  assign n_eff      = (act.burst == '0) ? (BURST_W+1)'(1) : {1'b0, act.burst};
  assign burst_last = ({1'b0, bcnt} + (BURST_W+1)'(1)) >= n_eff;
  assign busy       = (state == ST_RUN);

  always_comb begin
    state_n = state;
    k_n     = k;
    bcnt_n  = bcnt;
    act_n   = act;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        k_n    = '0;
        bcnt_n = '0;
        // Keep the config that qualified the start; otherwise track the shadow.
        if (start && !stop && act.mode != MODE_DISABLED && act.period != '0)
          state_n = ST_RUN;
        else
          act_n = shd;
      end
      ST_RUN: begin
        if (stop) begin
          state_n = ST_IDLE;
          k_n     = '0;
          bcnt_n  = '0;
        end else if (last) begin
          k_n   = '0;
          act_n = shd;
          if (act.mode == MODE_ONE_SHOT || (act.mode == MODE_BURST && burst_last)) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            bcnt_n  = '0;
          end else if (shd.mode == MODE_DISABLED || shd.period == '0) begin
            state_n = ST_IDLE;
            bcnt_n  = '0;
          end else if (act.mode == MODE_BURST && shd.mode == MODE_BURST) begin
            bcnt_n = bcnt + BURST_W'(1);
          end else begin
            bcnt_n = '0;
          end
        end else begin
          k_n = k + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    pulse_n = (state_n == ST_RUN) && (k_n < act_n.width);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      k         <= '0;
      bcnt      <= '0;
      act       <= '0;
      shd       <= '0;
      pulse_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      bcnt      <= bcnt_n;
      act       <= act_n;
      pulse_out <= pulse_n;
      done      <= done_n;
      if (wr) shd <= '{period: wr_period, width: wr_width, mode: wr_mode, burst: wr_burst};
    end
  end

endmodule

// File: rtl/multi_channel_pulse_generator.sv
// Multi-channel pulse generator top: config write decode fanned out to
// NUM_CH independent pulse_channel instances.
module multi_channel_pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  multi_channel_pulse_generator_if.slave cfg,
  input  logic [NUM_CH-1:0]     start,
  input  logic [NUM_CH-1:0]     stop,
  output logic [NUM_CH-1:0]     pulse_out,
  output logic [NUM_CH-1:0]     busy,
  output logic [NUM_CH-1:0]     done
);

  localparam int CH_W = ch_w(NUM_CH);

  // Out-of-range cfg_ch matches no index, so such writes fall on the floor.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(gi);
    logic wr;
    assign wr = cfg.cfg_we && (cfg.cfg_ch == IDX);

    pulse_channel #(.CNT_W(CNT_W), .BURST_W(BURST_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr        (wr),
      .wr_period (cfg.cfg_period),
      .wr_width  (cfg.cfg_width),
      .wr_mode   (mode_e'(cfg.cfg_mode)),
      .wr_burst  (cfg.cfg_burst),
      .start     (start[gi]),
      .stop      (stop[gi]),
      .pulse_out (pulse_out[gi]),
      .busy      (busy[gi]),
      .done      (done[gi])
    );
  end

endmodule

// File: tb/tb_multi_channel_pulse_generator.sv
// Directed bench for multi_channel_pulse_generator; five channels so that an
// out-of-range cfg_ch value is expressible.
module tb_multi_channel_pulse_generator;
  localparam int NUM_CH  = 5;
  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;
  localparam int CH_W    = $clog2(NUM_CH);

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] start, stop, pulse_out, busy, done;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_channel_pulse_generator_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) cfg_bus ();

  multi_channel_pulse_generator #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg       (cfg_bus),
    .start     (start),
    .stop      (stop),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shadow lands on the write edge, active one edge later while IDLE.
  task automatic cfg_write(input int ch, input int p, input int w, input int m, input int n);
    cfg_bus.cfg_we     = 1'b1;
    cfg_bus.cfg_ch     = CH_W'(ch);
    cfg_bus.cfg_period = CNT_W'(p);
    cfg_bus.cfg_width  = CNT_W'(w);
    cfg_bus.cfg_mode   = 2'(m);
    cfg_bus.cfg_burst  = BURST_W'(n);
    tick();
    cfg_bus.cfg_we = 1'b0;
  endtask

  task automatic go(input logic [NUM_CH-1:0] m);
    start = m;
    tick();
    start = '0;
  endtask

  task automatic halt(input logic [NUM_CH-1:0] m);
    stop = m;
    tick();
    stop = '0;
  endtask

  initial begin
    logic [NUM_CH-1:0] ev;
    int pp [NUM_CH];
    int ww [NUM_CH];
    reset = 1'b1; start = '0; stop = '0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_period = '0;
    cfg_bus.cfg_width = '0; cfg_bus.cfg_mode = '0; cfg_bus.cfg_burst = '0;
    tick(); tick();
    chk("rst_pulse", 32'(pulse_out), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    reset = 1'b0;
    tick();

    // ch0 continuous P=10 W=3, then P=4 W=1 written mid-period at k=5
    cfg_write(0, 10, 3, 1, 0); tick();
    go(5'b00001);
    for (int i = 0; i < 25; i++) begin
      chk("cont_pulse", 32'(pulse_out[0]), 32'((i % 10) < 3));
      chk("cont_busy",  32'(busy[0]), 1);
      chk("cont_done",  32'(done[0]), 0);
      tick();
    end
    cfg_write(0, 4, 1, 1, 0);
    for (int j = 0; j < 12; j++) begin
      chk("reprog_pulse", 32'(pulse_out[0]), (j < 4) ? 0 : 32'(((j - 4) % 4) < 1));
      chk("reprog_busy",  32'(busy[0]), 1);
      tick();
    end
    halt(5'b00001);
    chk("stop0_busy",  32'(busy[0]), 0);
    chk("stop0_pulse", 32'(pulse_out[0]), 0);
    chk("stop0_done",  32'(done[0]), 0);

    // ch1 burst P=5 W=2 N=3
    cfg_write(1, 5, 2, 3, 3); tick();
    go(5'b00010);
    for (int i = 0; i < 15; i++) begin
      chk("burst_pulse", 32'(pulse_out[1]), 32'((i % 5) < 2));
      chk("burst_busy",  32'(busy[1]), 1);
      chk("burst_done",  32'(done[1]), 0);
      tick();
    end
    chk("burst_end_done",  32'(done[1]), 1);
    chk("burst_end_busy",  32'(busy[1]), 0);
    chk("burst_end_pulse", 32'(pulse_out[1]), 0);
    tick();
    chk("burst_done_clr", 32'(done[1]), 0);

    // ch3 edge widths, one-shot, zero period
    cfg_write(3, 8, 0, 1, 0); tick();
    go(5'b01000);
    for (int i = 0; i < 10; i++) begin
      chk("w0_pulse", 32'(pulse_out[3]), 0);
      chk("w0_busy",  32'(busy[3]), 1);
      tick();
    end
    halt(5'b01000);
    cfg_write(3, 8, 12, 1, 0); tick();
    go(5'b01000);
    for (int i = 0; i < 10; i++) begin
      chk("wbig_pulse", 32'(pulse_out[3]), 1);
      tick();
    end
    halt(5'b01000);
    cfg_write(3, 3, 1, 2, 0); tick();
    go(5'b01000);
    chk("os_k0", 32'(pulse_out[3]), 1); tick();
    chk("os_k1", 32'(pulse_out[3]), 0); tick();
    chk("os_k2_done", 32'(done[3]), 0);
    chk("os_k2_busy", 32'(busy[3]), 1); tick();
    chk("os_done", 32'(done[3]), 1);
    chk("os_busy", 32'(busy[3]), 0);
    cfg_write(3, 0, 2, 1, 0); tick();
    go(5'b01000);
    chk("p0_busy", 32'(busy[3]), 0);
    tick();
    chk("p0_busy_later", 32'(busy[3]), 0);

    // ch2 burst: stop+start together, restart, reset mid-run
    cfg_write(2, 6, 2, 3, 4); tick();
    go(5'b00100);
    tick(); tick(); tick();
    start = 5'b00100; stop = 5'b00100;
    tick();
    start = '0; stop = '0;
    chk("ss_busy",  32'(busy[2]), 0);
    chk("ss_pulse", 32'(pulse_out[2]), 0);
    chk("ss_done",  32'(done[2]), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ss_no_done", 32'(done[2]), 0);
    end
    go(5'b00100);
    chk("restart_busy",  32'(busy[2]), 1);
    chk("restart_pulse", 32'(pulse_out[2]), 1);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_pulse", 32'(pulse_out), 0);
    chk("mid_rst_busy",  32'(busy), 0);
    chk("mid_rst_done",  32'(done), 0);
    reset = 1'b0;
    tick();
    go(5'b00100);
    chk("post_rst_start", 32'(busy), 0);

    // all channels together with distinct P/W, plus an out-of-range write
    pp = '{3, 4, 5, 6, 7};
    ww = '{1, 2, 3, 1, 4};
    for (int c = 0; c < NUM_CH; c++) cfg_write(c, pp[c], ww[c], 1, 0);
    cfg_write(5, 2, 2, 1, 0);
    cfg_write(7, 9, 9, 3, 1);
    tick();
    go('1);
    for (int i = 0; i < 14; i++) begin
      for (int c = 0; c < NUM_CH; c++) ev[c] = (i % pp[c]) < ww[c];
      chk("all_pulse", 32'(pulse_out), 32'(ev));
      chk("all_busy",  32'(busy), 32'({NUM_CH{1'b1}}));
      tick();
    end
    halt('1);
    chk("all_stop", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
